axi_burst_writer: RTL and testbench

Parametrised AXI3 write-burst DMA engine that streams samples from a valid/ready source into a DDR region through the HP port. Unlike the fixed first-generation controller, it has runtime-configurable base and length, an internal show-ahead input FIFO, a circular mode, B-channel error handling, and abort at burst boundaries. It sits between the PDH capture path and the PS HP0 slave port; software reads status through the register bank.

---
 rtl/dma_pkg.sv | 21 ++
 rtl/posedge_detector.sv | 24 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/axi_burst_writer.sv | 207 ++++++++++++++++++++
 tb/tb_axi_burst_writer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and AXI constants for the burst writer
package dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      ADDR,
      DATA,
      RESP,
      DONE,
      ERROR
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   function automatic logic [2:0] axi_size(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/posedge_detector.sv
// rtl/posedge_detector.sv - registers a level once and flags its rising edge
module posedge_detector (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic pulse
);

   logic sig_q;
   logic sig_qq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q  <= 1'b0;
         sig_qq <= 1'b0;
      end else begin
         sig_q  <= sig;
         sig_qq <= sig_q;
      end
   end

   assign pulse = sig_q & ~sig_qq;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead single-clock FIFO with occupancy count and flush
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & (count != '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/axi_burst_writer.sv
// rtl/axi_burst_writer.sv - AXI3 write-burst DMA from a valid/ready sample stream
module axi_burst_writer
   import dma_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int ADDR_W      = 32,
   parameter int BURST_BEATS = 16,
   parameter int FIFO_DEPTH  = 64,
   parameter int CNT_W       = 24
) (
   input  logic                aclk,
   input  logic                rst_ni,
   input  logic [ADDR_W-1:0]   cfg_base_addr_i,
   input  logic [CNT_W-1:0]    cfg_num_bursts_i,
   input  logic                cfg_circular_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [DATA_W-1:0]   s_data_i,
   input  logic                s_valid_i,
   output logic                s_ready_o,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [3:0]          m_axi_awlen,
   output logic [2:0]          m_axi_awsize,
   output logic [1:0]          m_axi_awburst,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   output logic                m_axi_wlast,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   input  logic [1:0]          m_axi_bresp,
   output logic                busy_o,
   output logic                done_o,
   output logic                error_o,
   output logic [ADDR_W-1:0]   err_addr_o,
   output logic                wrap_o,
   output logic [CNT_W-1:0]    bursts_done_o,
   output logic [15:0]         drop_cnt_o
);

   localparam int BEAT_W      = $clog2(BURST_BEATS);
   localparam int FIFO_CW     = $clog2(FIFO_DEPTH) + 1;
   localparam int BURST_BYTES = BURST_BEATS * DATA_W / 8;
   localparam logic [ADDR_W-1:0]  ALIGN_MASK = ADDR_W'(BURST_BYTES - 1);
   localparam logic [ADDR_W-1:0]  BURST_INC  = ADDR_W'(BURST_BYTES);
   localparam logic [FIFO_CW-1:0] FILL_LEVEL = FIFO_CW'(BURST_BEATS);
   localparam logic [BEAT_W-1:0]  PRE_LAST   = BEAT_W'(BURST_BEATS - 2);

   state_t              state;
   logic [ADDR_W-1:0]   addr_r;
   logic [ADDR_W-1:0]   base_r;
   logic [CNT_W-1:0]    num_r;
   logic                circ_r;
   logic                abort_q;
   logic [BEAT_W-1:0]   beat;
   logic [FIFO_CW-1:0]  fifo_count;
   logic                fifo_full;
   logic                start_edge;
   logic                start_ok;
   logic [CNT_W-1:0]    bursts_next;

   posedge_detector u_start (
      .clk   (aclk),
      .rst_n (rst_ni),
      .sig   (start_i),
      .pulse (start_edge)
   );

   assign start_ok    = start_edge & ((state == IDLE) | (state == DONE) | (state == ERROR));
   assign s_ready_o   = busy_o & ~fifo_full;
   assign bursts_next = bursts_done_o + CNT_W'(1);

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (aclk),
      .rst_n (rst_ni),
      .flush (start_ok),
      .push  (s_valid_i & s_ready_o),
      .din   (s_data_i),
      .pop   (m_axi_wvalid & m_axi_wready),
      .dout  (m_axi_wdata),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign m_axi_awaddr  = addr_r;
   assign m_axi_awlen   = 4'(BURST_BEATS - 1);
   assign m_axi_awsize  = axi_size(DATA_W);
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_wstrb   = '1;

   always_ff @(posedge aclk or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         addr_r        <= '0;
         base_r        <= '0;
         num_r         <= '0;
         circ_r        <= 1'b0;
         abort_q       <= 1'b0;
         beat          <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_wlast   <= 1'b0;
         m_axi_bready  <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         error_o       <= 1'b0;
         err_addr_o    <= '0;
         wrap_o        <= 1'b0;
         bursts_done_o <= '0;
         drop_cnt_o    <= '0;
      end else begin
         wrap_o <= 1'b0;
         if (busy_o && abort_i) abort_q <= 1'b1;
         if (busy_o && s_valid_i && !s_ready_o && drop_cnt_o != 16'hffff)
            drop_cnt_o <= drop_cnt_o + 16'd1;

         case (state)
            IDLE, DONE, ERROR: begin
               if (start_ok) begin
                  base_r        <= cfg_base_addr_i & ~ALIGN_MASK;
                  addr_r        <= cfg_base_addr_i & ~ALIGN_MASK;
                  num_r         <= cfg_num_bursts_i;
                  circ_r        <= cfg_circular_i;
                  abort_q       <= 1'b0;
                  error_o       <= 1'b0;
                  err_addr_o    <= '0;
                  bursts_done_o <= '0;
                  drop_cnt_o    <= '0;
                  if (cfg_num_bursts_i == '0) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state  <= FILL;
                     done_o <= 1'b0;
                     busy_o <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (abort_q) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else if (fifo_count >= FILL_LEVEL) begin
                  state         <= ADDR;
                  m_axi_awvalid <= 1'b1;
               end
            end
            ADDR: begin
               if (m_axi_awready) begin
                  state         <= DATA;
                  m_axi_awvalid <= 1'b0;
                  m_axi_wvalid  <= 1'b1;
                  m_axi_wlast   <= 1'b0;
                  beat          <= '0;
               end
            end
            DATA: begin
               if (m_axi_wready) begin
                  beat        <= beat + 1'b1;
                  m_axi_wlast <= (beat == PRE_LAST);
                  if (m_axi_wlast) begin
                     state        <= RESP;
                     m_axi_wvalid <= 1'b0;
                     m_axi_wlast  <= 1'b0;
                     m_axi_bready <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  if (m_axi_bresp != AXI_RESP_OKAY) begin
                     state      <= ERROR;
                     busy_o     <= 1'b0;
                     error_o    <= 1'b1;
                     err_addr_o <= addr_r;
                  end else begin
                     addr_r        <= addr_r + BURST_INC;
                     bursts_done_o <= bursts_next;
                     if (abort_q || (bursts_next == num_r && !circ_r)) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                     end else if (bursts_next == num_r) begin
                        state         <= FILL;
                        addr_r        <= base_r;
                        bursts_done_o <= '0;
                        wrap_o        <= 1'b1;
                     end else begin
                        state <= FILL;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_writer.sv
// tb/tb_axi_burst_writer.sv - randomized scoreboard bench for axi_burst_writer
module tb_axi_burst_writer;

   localparam int DATA_W      = 64;
   localparam int ADDR_W      = 32;
   localparam int BURST_BEATS = 16;
   localparam int FIFO_DEPTH  = 64;
   localparam int CNT_W       = 24;
   localparam logic [31:0] BURST_BYTES = 32'(BURST_BEATS * DATA_W / 8);

   logic              aclk = 1'b0;
   logic              rst_ni = 1'b0;
   logic [ADDR_W-1:0] cfg_base_addr_i = '0;
   logic [CNT_W-1:0]  cfg_num_bursts_i = '0;
   logic              cfg_circular_i = 1'b0;
   logic              start_i = 1'b0;
   logic              abort_i = 1'b0;
   logic [DATA_W-1:0] s_data_i = '0;
   logic              s_valid_i = 1'b0;
   logic              s_ready_o;
   logic [ADDR_W-1:0] m_axi_awaddr;
   logic              m_axi_awvalid;
   logic              m_axi_awready = 1'b0;
   logic [3:0]        m_axi_awlen;
   logic [2:0]        m_axi_awsize;
   logic [1:0]        m_axi_awburst;
   logic [DATA_W-1:0] m_axi_wdata;
   logic [7:0]        m_axi_wstrb;
   logic              m_axi_wvalid;
   logic              m_axi_wready = 1'b0;
   logic              m_axi_wlast;
   logic              m_axi_bvalid = 1'b0;
   logic              m_axi_bready;
   logic [1:0]        m_axi_bresp = 2'b00;
   logic              busy_o, done_o, error_o, wrap_o;
   logic [ADDR_W-1:0] err_addr_o;
   logic [CNT_W-1:0]  bursts_done_o;
   logic [15:0]       drop_cnt_o;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] w_exp[$];
   logic [31:0] aw_exp[$];
   int aw_cnt = 0, b_cnt = 0, w_beat = 0, wrap_cnt = 0, b_pending = 0;
   int err_burst = -1, drop_exp = 0, src_idx = 0, run_tag = 0;
   int aw_pct = 70, w_pct = 70;
   bit src_en = 1'b0, src_cont = 1'b1, src_acc = 1'b0;

   axi_burst_writer dut (
      .aclk             (aclk),
      .rst_ni           (rst_ni),
      .cfg_base_addr_i  (cfg_base_addr_i),
      .cfg_num_bursts_i (cfg_num_bursts_i),
      .cfg_circular_i   (cfg_circular_i),
      .start_i          (start_i),
      .abort_i          (abort_i),
      .s_data_i         (s_data_i),
      .s_valid_i        (s_valid_i),
      .s_ready_o        (s_ready_o),
      .m_axi_awaddr     (m_axi_awaddr),
      .m_axi_awvalid    (m_axi_awvalid),
      .m_axi_awready    (m_axi_awready),
      .m_axi_awlen      (m_axi_awlen),
      .m_axi_awsize     (m_axi_awsize),
      .m_axi_awburst    (m_axi_awburst),
      .m_axi_wdata      (m_axi_wdata),
      .m_axi_wstrb      (m_axi_wstrb),
      .m_axi_wvalid     (m_axi_wvalid),
      .m_axi_wready     (m_axi_wready),
      .m_axi_wlast      (m_axi_wlast),
      .m_axi_bvalid     (m_axi_bvalid),
      .m_axi_bready     (m_axi_bready),
      .m_axi_bresp      (m_axi_bresp),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .error_o          (error_o),
      .err_addr_o       (err_addr_o),
      .wrap_o           (wrap_o),
      .bursts_done_o    (bursts_done_o),
      .drop_cnt_o       (drop_cnt_o)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: event not expected or not reached", name);
   endtask

   // Slave responder and monitor: drive inputs first, then score the handshakes
   // that the coming rising edge will complete.
   always @(negedge aclk) begin
      logic [63:0] exp_w;
      m_axi_awready = ($urandom_range(0, 99) < aw_pct);
      m_axi_wready  = ($urandom_range(0, 99) < w_pct);
      m_axi_bvalid  = (b_pending > 0) && ($urandom_range(0, 99) < 60);
      m_axi_bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      if (!s_valid_i || src_acc)
         s_valid_i = src_en && (src_cont || $urandom_range(0, 3) != 0);
      s_data_i = {32'(run_tag), 32'(src_idx)};

      if (rst_ni) begin
         chk("s_ready", s_ready_o, busy_o && (w_exp.size() < FIFO_DEPTH));
         if (busy_o && s_valid_i && !s_ready_o) drop_exp++;
         src_acc = s_valid_i && s_ready_o;
         if (src_acc) begin
            w_exp.push_back(s_data_i);
            src_idx++;
         end
         if (m_axi_awvalid && m_axi_awready) begin
            aw_cnt++;
            if (aw_exp.size() == 0) flag("unexpected_aw");
            else chk("aw", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awaddr},
                     {4'hf, 3'd3, 2'b01, aw_exp.pop_front()});
         end
         if (m_axi_wvalid && m_axi_wready) begin
            if (w_exp.size() == 0) flag("w_underflow");
            else begin
               exp_w = w_exp.pop_front();
               chk("wdata", m_axi_wdata, exp_w);
               chk("wlast", m_axi_wlast, (w_beat % BURST_BEATS) == BURST_BEATS - 1);
            end
            if (m_axi_wlast) b_pending++;
            w_beat++;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            b_pending--;
            b_cnt++;
         end
         if (wrap_o) wrap_cnt++;
      end
   end

   task automatic start_run(input logic [31:0] base, input int num, input bit circ,
                            input int errb, input int n_aw);
      logic [31:0] aligned;
      start_i = 1'b0;
      repeat (3) @(posedge aclk);
      #2;
      aligned          = base & ~32'h7f;
      cfg_base_addr_i  = base;
      cfg_num_bursts_i = 24'(num);
      cfg_circular_i   = circ;
      err_burst        = errb;
      w_exp.delete();
      aw_exp.delete();
      aw_cnt = 0; b_cnt = 0; w_beat = 0; wrap_cnt = 0; drop_exp = 0; src_idx = 0;
      run_tag++;
      for (int k = 0; k < n_aw; k++) aw_exp.push_back(aligned + 32'(k % num) * BURST_BYTES);
      start_i = 1'b1;
      repeat (3) @(posedge aclk);
      #2;
   endtask

   task automatic wait_end(input int limit);
      int n = 0;
      while (!(done_o || error_o) && n < limit) begin
         @(posedge aclk);
         #2;
         n++;
      end
      if (n >= limit) flag("timeout_end");
   endtask

   task automatic wait_aw(input int target, input int limit);
      int n = 0;
      while (aw_cnt < target && n < limit) begin
         @(posedge aclk);
         #2;
         n++;
      end
      if (n >= limit) flag("timeout_aw");
   endtask

   initial begin
      repeat (4) @(posedge aclk);
      #2;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_error", error_o, 0);
      chk("rst_wrap", wrap_o, 0);
      chk("rst_bursts", bursts_done_o, 0);
      chk("rst_drop", drop_cnt_o, 0);
      chk("rst_ready", s_ready_o, 0);
      chk("rst_chan_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}, 0);
      chk("rst_consts", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wstrb},
          {4'hf, 3'd3, 2'b01, 8'hff});
      rst_ni = 1'b1;
      src_en = 1'b1;

      // Four plain bursts with continuous source
      start_run(32'h4300_0000, 4, 1'b0, -1, 4);
      wait_end(3000);
      chk("t1_done", {done_o, error_o, busy_o}, 3'b100);
      chk("t1_bursts", bursts_done_o, 4);
      chk("t1_beats", w_beat, 64);
      chk("t1_aw_left", aw_exp.size(), 0);
      chk("t1_drop", drop_cnt_o, drop_exp);

      // Unaligned base is masked down
      start_run(32'h4300_0013, 1, 1'b0, -1, 1);
      wait_end(1000);
      chk("t2_done", done_o, 1);
      chk("t2_aw_left", aw_exp.size(), 0);

      // Zero bursts completes immediately
      start_run(32'h4300_0400, 0, 1'b0, -1, 0);
      wait_end(20);
      chk("t0_done", {done_o, busy_o}, 2'b10);
      chk("t0_aw", aw_cnt, 0);

      // Circular with 2 bursts, stopped after 5 via abort
      start_run(32'h4300_0800, 2, 1'b1, -1, 5);
      wait_aw(5, 3000);
      chk("t3_busy", busy_o, 1);
      chk("t3_wraps_mid", wrap_cnt, 2);
      abort_i = 1'b1;
      wait_end(1000);
      abort_i = 1'b0;
      chk("t3_done", done_o, 1);
      chk("t3_bursts", bursts_done_o, 1);
      chk("t3_wraps", wrap_cnt, 2);
      chk("t3_aw_left", aw_exp.size(), 0);

      // Error response on the second burst
      start_run(32'h4300_1000, 4, 1'b0, 1, 2);
      wait_end(2000);
      chk("t4_flags", {error_o, done_o, busy_o}, 3'b100);
      chk("t4_err_addr", err_addr_o, 32'h4300_1080);
      chk("t4_bursts", bursts_done_o, 1);
      repeat (30) @(posedge aclk);
      #2;
      chk("t4_aw_cnt", aw_cnt, 2);
      chk("t4_aw_left", aw_exp.size(), 0);

      // Abort pulsed during burst 1 of 8
      start_run(32'h4300_2000, 8, 1'b0, -1, 2);
      wait_aw(2, 2000);
      repeat (3) @(posedge aclk);
      #2;
      abort_i = 1'b1;
      @(posedge aclk);
      #2;
      abort_i = 1'b0;
      wait_end(1000);
      chk("t5_done", done_o, 1);
      chk("t5_bursts", bursts_done_o, 2);
      chk("t5_beats", w_beat, 32);
      chk("t5_aw_left", aw_exp.size(), 0);

      // Heavy back-pressure, restart attempt while busy
      aw_pct = 40;
      w_pct  = 35;
      start_run(32'h4300_3000, 6, 1'b0, -1, 6);
      wait_aw(2, 3000);
      start_i = 1'b0;
      @(posedge aclk);
      #2;
      start_i = 1'b1;
      wait_end(5000);
      chk("t6_done", done_o, 1);
      chk("t6_bursts", bursts_done_o, 6);
      chk("t6_beats", w_beat, 96);
      chk("t6_drop", drop_cnt_o, drop_exp);
      chk("t6_aw_left", aw_exp.size(), 0);

      // Bursty source with random gaps on every channel
      src_cont = 1'b0;
      aw_pct   = 60;
      w_pct    = 60;
      start_run(32'h4300_5040, 3, 1'b0, -1, 3);
      wait_end(4000);
      chk("t7_done", done_o, 1);
      chk("t7_bursts", bursts_done_o, 3);
      chk("t7_beats", w_beat, 48);
      chk("t7_drop", drop_cnt_o, drop_exp);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
